// File: rtl/alpha_perm_stage.sv
// One-deep valid/ready stage applying a per-row cyclic rotation to an N x N state,
// with an XOR-signature check across its own storage for concurrent error detection.
module alpha_perm_stage #(
    parameter int W         = 8,
    parameter int N         = 4,
    parameter int ROT       = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_mode,
    input  logic [N*N*W-1:0]     in_data,
    input  logic                 fi_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*N*W-1:0]     out_data,
    output logic                 out_err,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int ROT_M = ROT % N;

    logic [N*N*W-1:0]     fault_data;
    logic [N*N*W-1:0]     perm_data;
    logic [W-1:0]         in_sig;
    logic [W-1:0]         out_sig;
    logic [N*N*W-1:0]     data_reg;
    logic [W-1:0]         sig_reg;
    logic                 valid_reg;
    logic [ERR_CNT_W-1:0] cnt_reg;
    logic                 accept;

    assign in_ready = !valid_reg | out_ready;
    assign accept   = in_valid & in_ready;

    // Fault lands on input element [0][0] ahead of the permutation, so it ends up
    // wherever that element is routed; the signature below ignores it.
    always_comb begin
        fault_data    = in_data;
        fault_data[0] = in_data[0] ^ fi_en;
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        localparam int K0 = ROT_M;
        localparam int K1 = gi % N;
        localparam int K2 = (N - gi) % N;
        localparam int K3 = (N - ROT_M) % N;
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            localparam int S0 = (gj + K0) % N;
            localparam int S1 = (gj + K1) % N;
            localparam int S2 = (gj + K2) % N;
            localparam int S3 = (gj + K3) % N;
            assign perm_data[(gi*N+gj)*W +: W] =
                (in_mode == 2'd0) ? fault_data[(gi*N+S0)*W +: W] :
                (in_mode == 2'd1) ? fault_data[(gi*N+S1)*W +: W] :
                (in_mode == 2'd2) ? fault_data[(gi*N+S2)*W +: W] :
                                    fault_data[(gi*N+S3)*W +: W];
        end
    end

    always_comb begin
        in_sig  = '0;
        out_sig = '0;
        for (int i = 0; i < N*N; i++) begin
            in_sig  = in_sig ^ in_data[i*W +: W];
            out_sig = out_sig ^ data_reg[i*W +: W];
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_err   = valid_reg & (out_sig != sig_reg);
    assign err_cnt   = cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            sig_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            if (accept) begin
                data_reg  <= perm_data;
                sig_reg   <= in_sig;
                valid_reg <= 1'b1;
            end else if (out_ready) begin
                valid_reg <= 1'b0;
            end

            if (err_clr) begin
                cnt_reg <= '0;
            end else if (valid_reg && out_ready && out_err && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + ERR_CNT_W'(1);
            end
        end
    end

endmodule
